// File: rtl/flt2int_pkg.sv
// Shared types for the sequential float-to-integer converter.
package flt2int_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

    typedef enum logic [2:0] {ZERO, NEG_E, NORM, BIG, INF, NAN} cls_t;

    typedef enum logic {RND_TRUNC, RND_RNE} round_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flt2int_classify.sv
// Combinational decode of a packed float: sign, debiased exponent,
// significand with hidden bit, operand class and alignment shift.
module flt2int_classify
    import flt2int_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int INT_W = 16,
    parameter int K_W   = 5
) (
    input  logic [EXP_W+MAN_W:0]  flt_in,
    output logic                  sign,
    output logic signed [EXP_W:0] e,
    output logic [MAN_W:0]        m,
    output cls_t                  cls,
    output logic                  dir_left,
    output logic [K_W-1:0]        k
);
    localparam int BIAS = 2**(EXP_W-1) - 1;

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] mant_f;
    int               diff;

    assign sign   = flt_in[EXP_W+MAN_W];
    assign exp_f  = flt_in[EXP_W+MAN_W-1:MAN_W];
    assign mant_f = flt_in[MAN_W-1:0];
    assign e      = $signed({1'b0, exp_f}) - $signed((EXP_W+1)'(BIAS));
    assign m      = {|exp_f, mant_f};

    // Class priority: zero/subnormal, inf/NaN, then range checks on e
    always_comb begin
        cls      = NORM;
        dir_left = 1'b0;
        k        = {K_W{1'b0}};
        diff     = 0;
        if (exp_f == {EXP_W{1'b0}}) begin
            cls = ZERO;
        end else if (exp_f == {EXP_W{1'b1}}) begin
            cls = (mant_f == {MAN_W{1'b0}}) ? INF : NAN;
        end else if (e[EXP_W]) begin
            cls = NEG_E;
        end else if (int'(e) > INT_W - 2) begin
            cls = BIG;
        end else begin
            diff     = int'(e) - MAN_W;
            dir_left = (diff >= 0);
            k        = K_W'((diff >= 0) ? diff : -diff);
        end
    end

endmodule

// File: rtl/flt2int_seq_conv.sv
// Multi-cycle float-to-integer converter: aligns the significand one bit per
// cycle, then rounds, saturates and formats the result in a single step.
module flt2int_seq_conv
    import flt2int_pkg::*;
#(
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 10,
    parameter int INT_W    = 16,
    parameter int OUT_TWOS = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 round_mode,
    input  logic [EXP_W+MAN_W:0] flt_in,
    output logic                 busy,
    output logic                 done,
    output logic [INT_W-1:0]     int_out,
    output logic                 ovf,
    output logic                 invalid,
    output logic                 inexact
);
    localparam int MAG_W  = max_int(INT_W, MAN_W + 1);
    localparam int MAX_SH = max_int(MAN_W, INT_W - 2 - MAN_W);
    localparam int K_W    = $clog2(MAX_SH) + 1;

    logic                  sign_s;
    logic signed [EXP_W:0] e_s;
    logic [MAN_W:0]        m_s;
    cls_t                  cls_s;
    logic                  left_s;
    logic [K_W-1:0]        k_s;
    logic                  neg_up_s;

    state_t           state_r, state_n;
    cls_t             cls_r;
    logic             sign_r, rne_r, neg_up_r, left_r;
    logic [MAG_W-1:0] mag_r;
    logic             guard_r, sticky_r;
    logic [K_W-1:0]   cnt_r;

    logic [MAG_W:0]   rnd_mag_s;
    logic [INT_W-2:0] res_mag_s;
    logic             res_ovf_s, res_inv_s, res_inx_s, res_sign_s;
    logic [INT_W-1:0] res_word_s;

    flt2int_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .INT_W (INT_W),
        .K_W   (K_W)
    ) u_classify (
        .flt_in   (flt_in),
        .sign     (sign_s),
        .e        (e_s),
        .m        (m_s),
        .cls      (cls_s),
        .dir_left (left_s),
        .k        (k_s)
    );

    // Only e == -1 with a nonzero fraction lies strictly above one half
    assign neg_up_s = (e_s == {(EXP_W+1){1'b1}}) && (|m_s[MAN_W-1:0]);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_n;
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n = (cls_s == NORM && k_s != {K_W{1'b0}}) ? SHIFT : ROUND;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == K_W'(1)) state_n = ROUND;
                else                  state_n = SHIFT;
            end
            ROUND:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Rounding, saturation and output formatting for the ROUND step
    always_comb begin
        rnd_mag_s  = {1'b0, mag_r};
        res_mag_s  = {(INT_W-1){1'b0}};
        res_ovf_s  = 1'b0;
        res_inv_s  = 1'b0;
        res_inx_s  = 1'b0;
        res_sign_s = sign_r;
        case (cls_r)
            NORM: begin
                if (rne_r && guard_r && (sticky_r || mag_r[0])) begin
                    rnd_mag_s = {1'b0, mag_r} + {{MAG_W{1'b0}}, 1'b1};
                end else begin
                    rnd_mag_s = {1'b0, mag_r};
                end
                res_inx_s = guard_r | sticky_r;
                if (|rnd_mag_s[MAG_W:INT_W-1]) begin
                    res_mag_s = {(INT_W-1){1'b1}};
                    res_ovf_s = 1'b1;
                end else begin
                    res_mag_s = rnd_mag_s[INT_W-2:0];
                end
            end
            ZERO: res_inx_s = |mag_r;
            NEG_E: begin
                res_mag_s = (rne_r && neg_up_r) ? {{(INT_W-2){1'b0}}, 1'b1} : {(INT_W-1){1'b0}};
                res_inx_s = 1'b1;
            end
            BIG, INF: begin
                res_mag_s = {(INT_W-1){1'b1}};
                res_ovf_s = 1'b1;
            end
            NAN: begin
                res_mag_s  = {(INT_W-1){1'b1}};
                res_ovf_s  = 1'b1;
                res_inv_s  = 1'b1;
                res_sign_s = 1'b0;
            end
            default: res_mag_s = {(INT_W-1){1'b0}};
        endcase
        if (OUT_TWOS != 0) begin
            res_word_s = res_sign_s ? -{1'b0, res_mag_s} : {1'b0, res_mag_s};
        end else begin
            res_word_s = {res_sign_s, res_mag_s};
        end
    end

    // Operand latch, alignment shifter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_r    <= ZERO;
            sign_r   <= 1'b0;
            rne_r    <= 1'b0;
            neg_up_r <= 1'b0;
            left_r   <= 1'b0;
            mag_r    <= {MAG_W{1'b0}};
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            cnt_r    <= {K_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            int_out  <= {INT_W{1'b0}};
            ovf      <= 1'b0;
            invalid  <= 1'b0;
            inexact  <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_n != IDLE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cls_r    <= cls_s;
                        sign_r   <= sign_s;
                        rne_r    <= (round_t'(round_mode) == RND_RNE);
                        neg_up_r <= neg_up_s;
                        left_r   <= left_s;
                        mag_r    <= MAG_W'(m_s);
                        guard_r  <= 1'b0;
                        sticky_r <= 1'b0;
                        cnt_r    <= k_s;
                        ovf      <= 1'b0;
                        invalid  <= 1'b0;
                        inexact  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (left_r) begin
                        mag_r <= {mag_r[MAG_W-2:0], 1'b0};
                    end else begin
                        mag_r    <= {1'b0, mag_r[MAG_W-1:1]};
                        guard_r  <= mag_r[0];
                        sticky_r <= sticky_r | guard_r;
                    end
                    cnt_r <= cnt_r - K_W'(1);
                end
                ROUND: begin
                    int_out <= res_word_s;
                    ovf     <= res_ovf_s;
                    invalid <= res_inv_s;
                    inexact <= res_inx_s;
                    done    <= 1'b1;
                end
                default: done <= 1'b0;
            endcase
        end
    end

endmodule
